// File: rtl/alu_share_arb.sv
// Two-port arbiter that time-shares one combinational RV32I ALU: latches the winning operand
// bundle, registers Result/Zero/Less and returns them on a valid/ready handshake.
// Optional grant statistics outputs are enabled by defining ALU_SHARE_ARB_STATS_EN.
module alu_share_arb #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_rs1,
  input  logic [31:0] req0_rs2,
  input  logic [31:0] req0_imm,
  input  logic [31:0] req0_pc,
  input  logic        req0_asrc,
  input  logic [1:0]  req0_bsrc,
  input  logic [3:0]  req0_ctr,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_rs1,
  input  logic [31:0] req1_rs2,
  input  logic [31:0] req1_imm,
  input  logic [31:0] req1_pc,
  input  logic        req1_asrc,
  input  logic [1:0]  req1_bsrc,
  input  logic [3:0]  req1_ctr,
  output logic [31:0] alu_rs1,
  output logic [31:0] alu_rs2,
  output logic [31:0] alu_imm,
  output logic [31:0] alu_pc,
  output logic        alu_asrc,
  output logic [1:0]  alu_bsrc,
  output logic [3:0]  alu_ctr,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  input  logic        alu_less,
  output logic        rsp0_valid,
  output logic        rsp1_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_zero,
  output logic        rsp_less,
  output logic        busy
`ifdef ALU_SHARE_ARB_STATS_EN
  ,
  output logic [15:0] stat_grant0,
  output logic [15:0] stat_grant1,
  output logic [7:0]  stat_starve
`endif
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  localparam logic [3:0] CtrIdle = 4'b0011;
  localparam logic [3:0] Limit   = 4'(STARVE_LIMIT);

  state_e     state_q, state_d;
  logic [3:0] starve_q, starve_d;
  logic       id_q;
  logic       grant0, grant1, forced;
  logic       less_ok;

  // Port 0 wins unless port 1 has waited through Limit consecutive port-0 grants.
  always_comb begin
    forced = req0_valid & req1_valid & (starve_q == Limit);
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == StIdle) begin
      grant1 = req1_valid & (~req0_valid | forced);
      grant0 = req0_valid & ~grant1;
    end
  end

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    unique case (state_q)
      StIdle: begin
        if (grant0 | grant1) begin
          state_d  = StExec;
          starve_d = (grant0 & req1_valid) ? starve_q + 4'd1 : 4'd0;
        end
      end
      StExec:  state_d = StResp;
      StResp:  if (rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Less is only meaningful for the two compare ops.
  assign less_ok = (alu_ctr == 4'b0010) || (alu_ctr == 4'b1010);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      starve_q   <= 4'd0;
      id_q       <= 1'b0;
      alu_rs1    <= 32'd0;
      alu_rs2    <= 32'd0;
      alu_imm    <= 32'd0;
      alu_pc     <= 32'd0;
      alu_asrc   <= 1'b0;
      alu_bsrc   <= 2'd0;
      alu_ctr    <= CtrIdle;
      rsp_result <= 32'd0;
      rsp_zero   <= 1'b0;
      rsp_less   <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      if (grant0 | grant1) begin
        id_q     <= grant1;
        alu_rs1  <= grant1 ? req1_rs1  : req0_rs1;
        alu_rs2  <= grant1 ? req1_rs2  : req0_rs2;
        alu_imm  <= grant1 ? req1_imm  : req0_imm;
        alu_pc   <= grant1 ? req1_pc   : req0_pc;
        alu_asrc <= grant1 ? req1_asrc : req0_asrc;
        alu_bsrc <= grant1 ? req1_bsrc : req0_bsrc;
        alu_ctr  <= grant1 ? req1_ctr  : req0_ctr;
      end else if ((state_q == StResp) && rsp_ready) begin
        alu_rs1  <= 32'd0;
        alu_rs2  <= 32'd0;
        alu_imm  <= 32'd0;
        alu_pc   <= 32'd0;
        alu_asrc <= 1'b0;
        alu_bsrc <= 2'd0;
        alu_ctr  <= CtrIdle;
      end
      if (state_q == StExec) begin
        rsp_result <= alu_result;
        rsp_zero   <= alu_zero;
        rsp_less   <= less_ok & alu_less;
      end
    end
  end

  assign req0_ready = rst_n & grant0;
  assign req1_ready = rst_n & grant1;
  assign rsp0_valid = (state_q == StResp) & ~id_q;
  assign rsp1_valid = (state_q == StResp) & id_q;
  assign busy       = (state_q != StIdle);

`ifdef ALU_SHARE_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_grant0 <= 16'd0;
      stat_grant1 <= 16'd0;
      stat_starve <= 8'd0;
    end else begin
      if (grant0 && (stat_grant0 != 16'hFFFF)) stat_grant0 <= stat_grant0 + 16'd1;
      if (grant1 && (stat_grant1 != 16'hFFFF)) stat_grant1 <= stat_grant1 + 16'd1;
      if (grant1 && forced && (stat_starve != 8'hFF)) stat_starve <= stat_starve + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_share_arb.sv
// Scoreboard bench for alu_share_arb: random and directed requests, a behavioural ALU on the
// alu_* side, and a cycle monitor comparing handshakes and responses against a reference model.
module tb_alu_share_arb;

  localparam int unsigned Limit = 4;

  typedef struct packed {
    logic        valid;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic        asrc;
    logic [1:0]  bsrc;
    logic [3:0]  ctr;
  } req_t;

  typedef struct packed {
    logic        port;
    req_t        req;
    logic [31:0] result;
    logic        zero;
    logic        less;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rsp_ready = 1'b0;
  req_t r0 = '0;
  req_t r1 = '0;

  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy;
  logic [31:0] alu_rs1, alu_rs2, alu_imm, alu_pc, alu_result, rsp_result;
  logic        alu_asrc, alu_zero, alu_less, rsp_zero, rsp_less;
  logic [1:0]  alu_bsrc;
  logic [3:0]  alu_ctr;
`ifdef ALU_SHARE_ARB_STATS_EN
  logic [15:0] stat_grant0, stat_grant1;
  logic [7:0]  stat_starve;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_share_arb #(.STARVE_LIMIT(Limit)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (r0.valid),
    .req0_ready (req0_ready),
    .req0_rs1   (r0.rs1),
    .req0_rs2   (r0.rs2),
    .req0_imm   (r0.imm),
    .req0_pc    (r0.pc),
    .req0_asrc  (r0.asrc),
    .req0_bsrc  (r0.bsrc),
    .req0_ctr   (r0.ctr),
    .req1_valid (r1.valid),
    .req1_ready (req1_ready),
    .req1_rs1   (r1.rs1),
    .req1_rs2   (r1.rs2),
    .req1_imm   (r1.imm),
    .req1_pc    (r1.pc),
    .req1_asrc  (r1.asrc),
    .req1_bsrc  (r1.bsrc),
    .req1_ctr   (r1.ctr),
    .alu_rs1    (alu_rs1),
    .alu_rs2    (alu_rs2),
    .alu_imm    (alu_imm),
    .alu_pc     (alu_pc),
    .alu_asrc   (alu_asrc),
    .alu_bsrc   (alu_bsrc),
    .alu_ctr    (alu_ctr),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .alu_less   (alu_less),
    .rsp0_valid (rsp0_valid),
    .rsp1_valid (rsp1_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .rsp_less   (rsp_less),
    .busy       (busy)
`ifdef ALU_SHARE_ARB_STATS_EN
    ,
    .stat_grant0(stat_grant0),
    .stat_grant1(stat_grant1),
    .stat_starve(stat_starve)
`endif
  );

  // Behavioural RV32I ALU; Less for non-compare ops is deliberately junk.
  function automatic logic [33:0] alu_model(input logic [31:0] rs1, input logic [31:0] rs2,
                                            input logic [31:0] imm, input logic [31:0] pc,
                                            input logic asrc, input logic [1:0] bsrc,
                                            input logic [3:0] ctr);
    logic [31:0] a, b, y;
    logic        lt;
    a  = asrc ? pc : rs1;
    b  = (bsrc == 2'd0) ? rs2 : (bsrc == 2'd1) ? imm : 32'd4;
    lt = ctr[3] ? (a < b) : ($signed(a) < $signed(b));
    case (ctr[2:0])
      3'd0:    y = ctr[3] ? a - b : a + b;
      3'd1:    y = a << b[4:0];
      3'd2:    y = {31'd0, lt};
      3'd3:    y = b;
      3'd4:    y = a ^ b;
      3'd5:    y = ctr[3] ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6:    y = a | b;
      default: y = a & b;
    endcase
    if (ctr[2:0] != 3'd2) lt = a[0] ^ b[0];
    return {lt, (y == 32'd0), y};
  endfunction

  always_comb {alu_less, alu_zero, alu_result} =
      alu_model(alu_rs1, alu_rs2, alu_imm, alu_pc, alu_asrc, alu_bsrc, alu_ctr);

  function automatic exp_t make_exp(input logic port, input req_t q);
    exp_t        e;
    logic [33:0] m;
    m        = alu_model(q.rs1, q.rs2, q.imm, q.pc, q.asrc, q.bsrc, q.ctr);
    e.port   = port;
    e.req    = q;
    e.result = m[31:0];
    e.zero   = m[32];
    e.less   = m[33] & ((q.ctr == 4'b0010) || (q.ctr == 4'b1010));
    return e;
  endfunction

  function automatic req_t rand_req();
    req_t q;
    q.valid = 1'b1;
    q.rs1   = $urandom();
    q.rs2   = ($urandom_range(0, 3) == 0) ? q.rs1 : $urandom();
    q.imm   = $urandom();
    q.pc    = $urandom();
    q.asrc  = 1'($urandom_range(0, 1));
    q.bsrc  = 2'($urandom_range(0, 3));
    q.ctr   = 4'($urandom_range(0, 15));
    return q;
  endfunction

  task automatic check(input string name, input logic [159:0] got, input logic [159:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h required %0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic fail_timeout(input string name);
    tests++;
    fails++;
    $display("FAIL %s: got no handshake, required one within the cycle budget", name);
  endtask

  // Reference model, sampled on the falling edge.
  exp_t       sb[$];
  logic       grant_log[$];
  logic       m_free = 1'b1;
  int         m_age = 0;
  int         streak = 0;
  int         n_g0 = 0, n_g1 = 0, n_force = 0;
  logic       m_e0, m_e1, m_out;
  exp_t       m_f;
  req_t       m_cur;

  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      m_free  = 1'b1;
      m_age   = 0;
      streak  = 0;
      n_g0    = 0;
      n_g1    = 0;
      n_force = 0;
    end else begin
      if (!m_free) m_age++;
      m_f   = m_free ? '0 : sb[0];
      m_out = !m_free && (m_age >= 2);
      m_e0  = 1'b0;
      m_e1  = 1'b0;
      if (m_free && (r0.valid || r1.valid)) begin
        m_e1 = r1.valid && (!r0.valid || (streak == Limit));
        m_e0 = !m_e1;
      end
      check("ctl", {req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy},
            {m_e0, m_e1, m_out && !m_f.port, m_out && m_f.port, !m_free});
      m_cur = m_free ? '0 : m_f.req;
      if (m_free) m_cur.ctr = 4'b0011;
      check("alu_bundle", {alu_rs1, alu_rs2, alu_imm, alu_pc, alu_asrc, alu_bsrc, alu_ctr},
            {m_cur.rs1, m_cur.rs2, m_cur.imm, m_cur.pc, m_cur.asrc, m_cur.bsrc, m_cur.ctr});
      if (m_out) begin
        check("rsp_data", {rsp_result, rsp_zero, rsp_less}, {m_f.result, m_f.zero, m_f.less});
        if (rsp_ready) begin
          void'(sb.pop_front());
          m_free = 1'b1;
        end
      end
      if (m_e0 || m_e1) begin
        sb.push_back(make_exp(m_e1, m_e1 ? r1 : r0));
        grant_log.push_back(m_e1);
        m_free = 1'b0;
        m_age  = 0;
        if (m_e1) begin
          n_g1++;
          if (r0.valid) n_force++;
          streak = 0;
        end else begin
          n_g0++;
          streak = r1.valid ? streak + 1 : 0;
        end
      end
    end
  end

  // One cycle: sample ready on the falling edge, then advance past the rising edge.
  task automatic step(output logic g0, output logic g1);
    @(negedge clk);
    g0 = req0_ready;
    g1 = req1_ready;
    @(posedge clk);
    #1;
    if (g0) r0.valid = 1'b0;
    if (g1) r1.valid = 1'b0;
  endtask

  task automatic wait_idle();
    logic g0, g1;
    int   n;
    r0.valid  = 1'b0;
    r1.valid  = 1'b0;
    rsp_ready = 1'b1;
    n = 0;
    while (busy && n < 20) begin
      step(g0, g1);
      n++;
    end
    if (busy) fail_timeout("wait_idle");
  endtask

  task automatic issue(input logic p, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] ctr, input logic [33:0] want);
    req_t q;
    logic g0, g1;
    int   n;
    q = '0;
    q.valid = 1'b1;
    q.rs1   = a;
    q.rs2   = b;
    q.ctr   = ctr;
    rsp_ready = 1'b1;
    if (p) r1 = q;
    else r0 = q;
    g0 = 1'b0;
    g1 = 1'b0;
    n  = 0;
    while (!(p ? g1 : g0) && n < 20) begin
      step(g0, g1);
      n++;
    end
    if (!(p ? g1 : g0)) begin
      fail_timeout("issue_accept");
      wait_idle();
      return;
    end
    step(g0, g1);
    check("issue_rsp", {p ? rsp1_valid : rsp0_valid, rsp_result, rsp_zero, rsp_less},
          {1'b1, want});
    wait_idle();
  endtask

  initial begin
    logic       g0, g1;
    int         n;
    logic [9:0] order_pat;
    order_pat = 10'b10_0001_0000;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_out", {rsp_result, rsp_zero, rsp_less, rsp0_valid, rsp1_valid, busy,
                        alu_ctr, alu_rs1}, {32'd0, 5'd0, 4'b0011, 32'd0});
    @(posedge clk);
    #1;

    // Both ports valid back to back: port 1 forced in after Limit port-0 grants.
    grant_log.delete();
    rsp_ready = 1'b1;
    r0 = rand_req();
    r1 = rand_req();
    n  = 0;
    while (grant_log.size() < 10 && n < 80) begin
      step(g0, g1);
      if (g0) r0 = rand_req();
      if (g1) r1 = rand_req();
      n++;
    end
    if (grant_log.size() < 10) fail_timeout("grant_order");
    else for (int i = 0; i < 10; i++) check("grant_order", grant_log[i], order_pat[i]);
    wait_idle();

    // Reset during EXEC with port 1 pending.
    r0 = rand_req();
    step(g0, g1);
    check("pre_rst_grant", {g0, g1}, 2'b10);
    r1 = rand_req();
    rst_n = 1'b0;
    step(g0, g1);
    rst_n = 1'b1;
    check("post_rst_out", {rsp_result, rsp_zero, rsp_less, rsp0_valid, rsp1_valid, busy}, 0);
    step(g0, g1);
    check("post_rst_grant", {g0, g1}, 2'b01);
    wait_idle();

    // Directed ops: {result, zero, less}.
    issue(1'b0, 32'd5, 32'd7, 4'b0000, {32'd12, 1'b0, 1'b0});
    issue(1'b1, 32'hFFFF_FFFF, 32'd1, 4'b0010, {32'd1, 1'b0, 1'b1});
    issue(1'b1, 32'hFFFF_FFFF, 32'd1, 4'b1010, {32'd0, 1'b1, 1'b0});
    issue(1'b1, 32'd9, 32'd9, 4'b1000, {32'd0, 1'b1, 1'b0});

    // Consumer stall with port 1 waiting behind it.
    rsp_ready = 1'b0;
    r0 = rand_req();
    g0 = 1'b0;
    n  = 0;
    while (!g0 && n < 20) begin
      step(g0, g1);
      n++;
    end
    if (!g0) fail_timeout("stall_accept");
    r1 = rand_req();
    repeat (12) step(g0, g1);
    check("stall_hold", {g0, g1, busy, rsp0_valid}, 4'b0011);
    rsp_ready = 1'b1;
    step(g0, g1);
    check("stall_release", {g0, g1, busy}, 3'b000);
    step(g0, g1);
    check("stall_next_grant", {g0, g1}, 2'b01);
    wait_idle();

    // Random traffic with withdrawals and a randomly stalling consumer.
    for (int i = 0; i < 600; i++) begin
      step(g0, g1);
      rsp_ready = ($urandom_range(0, 9) < 7);
      if (!r0.valid && $urandom_range(0, 9) < 5) r0 = rand_req();
      else if (r0.valid && $urandom_range(0, 19) == 0) r0.valid = 1'b0;
      if (!r1.valid && $urandom_range(0, 9) < 4) r1 = rand_req();
      else if (r1.valid && $urandom_range(0, 19) == 0) r1.valid = 1'b0;
    end
    wait_idle();
    step(g0, g1);
    check("sb_drained", sb.size(), 0);

`ifdef ALU_SHARE_ARB_STATS_EN
    check("stat_grant0", stat_grant0, n_g0);
    check("stat_grant1", stat_grant1, n_g1);
    check("stat_starve", stat_starve, n_force);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
